// File: rtl/unified_mem_arb.sv
// Multi-port arbiter in front of a single-port byte-enable RAM; round-robin by default,
// fixed lowest-index priority when UMEM_ARB_FIXED_PRIO_EN is defined.
module unified_mem_arb #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     wdata,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [DATA_W-1:0]               rdata
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int WORD_W = ADDR_W - OFF_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [BYTES-1:0]     sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [WORD_W-1:0]    word_idx;
  logic                 wr_en;
  logic                 rd_en;
  logic [NUM_PORTS-1:0] rvalid_reg;

`ifdef UMEM_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = PTR_W'(i);
        gnt_any = 1'b1;
      end
    end
    if (reset) gnt_any = 1'b0;
  end
`else
  logic [PTR_W-1:0] last_grant_reg;

  // Scan farthest-to-nearest from last_grant so the nearest successor wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (req[(int'(last_grant_reg) + i) % NUM_PORTS]) begin
        gnt_idx = PTR_W'((int'(last_grant_reg) + i) % NUM_PORTS);
        gnt_any = 1'b1;
      end
    end
    if (reset) gnt_any = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PTR_W'(NUM_PORTS - 1);
    end else if (gnt_any) begin
      last_grant_reg <= gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign sel_we    = we[int'(gnt_idx)*BYTES +: BYTES];
  assign sel_addr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign word_idx  = sel_addr[ADDR_W-1:OFF_W];
  assign wr_en     = gnt_any && (|sel_we);
  assign rd_en     = gnt_any && !(|sel_we);

  // Byte offset within a word is deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, sel_addr[OFF_W-1:0]};

  // One narrow RAM per byte lane gives byte-write without read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (wr_en && sel_we[gi]) begin
          lane_mem[word_idx] <= sel_wdata[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_reg <= '0;
        end else if (rd_en) begin
          rd_reg <= lane_mem[word_idx];
        end
      end

      assign rdata[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_reg <= '0;
    end else begin
      rvalid_reg <= rd_en ? gnt : '0;
    end
  end

  // A read granted just before reset must not surface during the reset cycle.
  assign rvalid = rvalid_reg & {NUM_PORTS{~reset}};

endmodule
